// File: rtl/shared_reg_arb_pkg.sv
// Shared types and defaults for the shared-register arbiter.
package shared_reg_arb_pkg;

   typedef enum logic {UNLOCKED, LOCKED} lock_state_e;

   localparam int unsigned DEFAULT_LOCK_TIMEOUT = 16;
   localparam logic [63:0] DEFAULT_RESET_VAL    = 64'h0;

   function automatic int unsigned id_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr_i, wrapping.
module rr_arbiter
   import shared_reg_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4
) (
   input  logic [NUM_REQ-1:0]          req_i,
   input  logic [id_w(NUM_REQ)-1:0]    ptr_i,
   output logic [NUM_REQ-1:0]          gnt_o,
   output logic                        valid_o,
   output logic [id_w(NUM_REQ)-1:0]    idx_o
);

   localparam int unsigned IdW = id_w(NUM_REQ);

   always_comb begin
      int unsigned j;
      j       = 0;
      gnt_o   = '0;
      valid_o = 1'b0;
      idx_o   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         j = (32'(ptr_i) + i) % NUM_REQ;
         if (!valid_o && req_i[j]) begin
            valid_o  = 1'b1;
            idx_o    = IdW'(j);
            gnt_o[j] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/shared_reg_arbiter.sv
// One DATA_W-bit register shared by NUM_REQ valid/ready writers, round-robin with
// optional per-owner lock and an idle timeout that force-releases the lock.
module shared_reg_arbiter
   import shared_reg_arb_pkg::*;
#(
   parameter int unsigned         NUM_REQ      = 4,
   parameter int unsigned         DATA_W       = 32,
   parameter logic [DATA_W-1:0]   RESET_VAL    = DATA_W'(DEFAULT_RESET_VAL),
   parameter int unsigned         LOCK_TIMEOUT = DEFAULT_LOCK_TIMEOUT
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_REQ-1:0]            i_req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]     i_req_data,
   input  logic [NUM_REQ-1:0]            i_req_lock,
   output logic [NUM_REQ-1:0]            o_req_ready,
   output logic [DATA_W-1:0]             o_rd_data,
   output logic [id_w(NUM_REQ)-1:0]      o_last_id,
   output logic                          o_wr_pulse,
   output logic                          o_locked
);

   localparam int unsigned IdW  = id_w(NUM_REQ);
   localparam int unsigned CntW = $clog2(LOCK_TIMEOUT) + 1;
   localparam logic [CntW-1:0] CntLast = CntW'(LOCK_TIMEOUT - 1);
   localparam logic [IdW-1:0]  IdLast  = IdW'(NUM_REQ - 1);

   lock_state_e          state_q, state_d;
   logic [IdW-1:0]       ptr_q, ptr_d;
   logic [IdW-1:0]       owner_q, owner_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [DATA_W-1:0]    data_q, data_d;
   logic [IdW-1:0]       last_id_q, last_id_d;
   logic                 wr_pulse_q, wr_pulse_d;

   logic [NUM_REQ-1:0]   arb_gnt;
   logic                 arb_valid;
   logic [IdW-1:0]       arb_idx;

   logic [NUM_REQ-1:0]   ready;
   logic                 xfer;
   logic [IdW-1:0]       xfer_id;
   logic [DATA_W-1:0]    xfer_data;
   logic                 xfer_lock;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_rr_arbiter (
      .req_i   (i_req_valid),
      .ptr_i   (ptr_q),
      .gnt_o   (arb_gnt),
      .valid_o (arb_valid),
      .idx_o   (arb_idx)
   );

   // While locked, the owner is the only candidate even if it is idle.
   always_comb begin
      ready   = '0;
      xfer_id = arb_idx;
      if (state_q == LOCKED) begin
         xfer_id = owner_q;
         if (i_req_valid[owner_q]) ready[owner_q] = 1'b1;
      end else if (arb_valid) begin
         ready = arb_gnt;
      end
      if (i_rst) ready = '0;
   end

   assign xfer      = |ready;
   assign xfer_data = i_req_data[32'(xfer_id)*DATA_W +: DATA_W];
   assign xfer_lock = i_req_lock[xfer_id];

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      owner_d    = owner_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      last_id_d  = last_id_q;
      wr_pulse_d = 1'b0;

      if (xfer) begin
         data_d     = xfer_data;
         last_id_d  = xfer_id;
         wr_pulse_d = 1'b1;
         ptr_d      = (xfer_id == IdLast) ? '0 : xfer_id + 1'b1;
      end

      unique case (state_q)
         UNLOCKED: begin
            cnt_d = '0;
            if (xfer && xfer_lock) begin
               state_d = LOCKED;
               owner_d = xfer_id;
            end
         end
         LOCKED: begin
            if (xfer) begin
               cnt_d = '0;
               if (!xfer_lock) state_d = UNLOCKED;
            end else if (cnt_q == CntLast) begin
               cnt_d   = '0;
               state_d = UNLOCKED;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = UNLOCKED;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= UNLOCKED;
         ptr_q      <= '0;
         owner_q    <= '0;
         cnt_q      <= '0;
         data_q     <= RESET_VAL;
         last_id_q  <= '0;
         wr_pulse_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         owner_q    <= owner_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         last_id_q  <= last_id_d;
         wr_pulse_q <= wr_pulse_d;
      end
   end

   assign o_req_ready = ready;
   assign o_rd_data   = data_q;
   assign o_last_id   = last_id_q;
   assign o_wr_pulse  = wr_pulse_q;
   assign o_locked    = (state_q == LOCKED);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed bench for shared_reg_arbiter: reset, single write, rotation, lock burst,
// lock timeout and reset mid-burst, each with hand-computed expectations.
module tb_shared_reg_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [3:0]   valid;
   logic [127:0] data;
   logic [3:0]   lock;
   logic [3:0]   ready;
   logic [31:0]  rd_data;
   logic [1:0]   last_id;
   logic         wr_pulse;
   logic         locked;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   shared_reg_arbiter #(
      .NUM_REQ      (4),
      .DATA_W       (32),
      .RESET_VAL    (32'h0),
      .LOCK_TIMEOUT (16)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_req_valid (valid),
      .i_req_data  (data),
      .i_req_lock  (lock),
      .o_req_ready (ready),
      .o_rd_data   (rd_data),
      .o_last_id   (last_id),
      .o_wr_pulse  (wr_pulse),
      .o_locked    (locked)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst   = 1'b1;
      valid = 4'hF;
      data  = '0;
      lock  = '0;
      for (int k = 0; k < 4; k++) data[k*32 +: 32] = 32'h1000 + k;

      // Reset held with all requesters valid
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         check("rst_ready", 64'(ready), 64'h0);
      end
      check("rst_rd_data", 64'(rd_data), 64'h0);
      check("rst_wr_pulse", 64'(wr_pulse), 64'h0);
      check("rst_last_id", 64'(last_id), 64'h0);
      check("rst_locked", 64'(locked), 64'h0);
      rst   = 1'b0;
      valid = 4'h0;
      tick();

      // Single write by req1
      valid = 4'b0010;
      data[1*32 +: 32] = 32'hDEADBEEF;
      #1;
      check("single_ready", 64'(ready), 64'h2);
      tick();
      valid = 4'h0;
      #1;
      check("single_rd_data", 64'(rd_data), 64'hDEADBEEF);
      check("single_last_id", 64'(last_id), 64'h1);
      check("single_pulse_hi", 64'(wr_pulse), 64'h1);
      tick();
      check("single_pulse_lo", 64'(wr_pulse), 64'h0);
      check("single_hold", 64'(rd_data), 64'hDEADBEEF);

      // Reset for one cycle to return ptr to 0
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst2_rd_data", 64'(rd_data), 64'h0);

      // Fairness: all valid, data = k
      for (int k = 0; k < 4; k++) data[k*32 +: 32] = 32'(k);
      valid = 4'hF;
      for (int i = 0; i < 8; i++) begin
         #1;
         check("rr_ready", 64'(ready), 64'(4'b0001 << (i % 4)));
         if (i > 0) begin
            check("rr_rd_data", 64'(rd_data), 64'((i - 1) % 4));
            check("rr_pulse", 64'(wr_pulse), 64'h1);
         end
         tick();
      end
      valid = 4'h0;
      #1;
      check("rr_last_data", 64'(rd_data), 64'h3);
      check("rr_last_id", 64'(last_id), 64'h3);

      // Move ptr to 2 with one req1 write
      valid = 4'b0010;
      data[1*32 +: 32] = 32'h11;
      tick();
      valid = 4'h0;

      // Lock burst by req2 while req0 waits
      valid = 4'b0101;
      data[0*32 +: 32] = 32'h55;
      data[2*32 +: 32] = 32'hA1;
      lock  = 4'b0100;
      #1;
      check("burst1_ready", 64'(ready), 64'h4);
      tick();
      check("burst1_locked", 64'(locked), 64'h1);
      check("burst1_rd", 64'(rd_data), 64'hA1);
      data[2*32 +: 32] = 32'hA2;
      #1;
      check("burst2_ready", 64'(ready), 64'h4);
      tick();
      check("burst2_locked", 64'(locked), 64'h1);
      check("burst2_rd", 64'(rd_data), 64'hA2);
      data[2*32 +: 32] = 32'hA3;
      lock  = 4'b0000;
      #1;
      check("burst3_ready", 64'(ready), 64'h4);
      tick();
      check("burst3_unlocked", 64'(locked), 64'h0);
      check("burst3_rd", 64'(rd_data), 64'hA3);
      check("burst3_last_id", 64'(last_id), 64'h2);
      valid = 4'b0001;
      #1;
      check("burst_req0_ready", 64'(ready), 64'h1);
      tick();
      check("burst_req0_rd", 64'(rd_data), 64'h55);
      check("burst_req0_id", 64'(last_id), 64'h0);
      valid = 4'h0;

      // Lock timeout: req3 locks then goes idle, req1 waits
      valid = 4'b1000;
      lock  = 4'b1000;
      data[3*32 +: 32] = 32'hC3;
      #1;
      check("to_lock_ready", 64'(ready), 64'h8);
      tick();
      valid = 4'b0010;
      lock  = 4'b0000;
      data[1*32 +: 32] = 32'h77;
      for (int c = 1; c <= 16; c++) begin
         #1;
         check("to_blocked", 64'(ready), 64'h0);
         check("to_locked", 64'(locked), 64'h1);
         tick();
      end
      check("to_release_ready", 64'(ready), 64'h2);
      check("to_release_locked", 64'(locked), 64'h0);
      tick();
      valid = 4'h0;
      check("to_req1_rd", 64'(rd_data), 64'h77);
      check("to_req1_id", 64'(last_id), 64'h1);

      // Reset mid-burst
      valid = 4'b0001;
      lock  = 4'b0001;
      data[0*32 +: 32] = 32'hE0;
      #1;
      check("mid_ready", 64'(ready), 64'h1);
      tick();
      check("mid_locked", 64'(locked), 64'h1);
      rst = 1'b1;
      #1;
      check("mid_rst_ready", 64'(ready), 64'h0);
      tick();
      rst   = 1'b0;
      lock  = 4'b0000;
      valid = 4'b0011;
      #1;
      check("mid_locked_clr", 64'(locked), 64'h0);
      check("mid_rd_data", 64'(rd_data), 64'h0);
      check("mid_last_id", 64'(last_id), 64'h0);
      check("mid_pulse", 64'(wr_pulse), 64'h0);
      check("mid_first_gnt", 64'(ready), 64'h1);
      tick();
      check("mid_second_gnt", 64'(ready), 64'h2);
      valid = 4'h0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
